i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) byte engine: the responding end of the bus that the codec control I2C master drives. It oversamples SCL/SDA on the system clock and detects START and STOP conditions. It matches a 7-bit device address, shifts received write bytes out to user logic, and serialises user-supplied bytes onto SDA for reads. Used for loopback verification of the master and for exposing an FPGA-side register file over the same bus.

## Interface
- `C_ADDR`, default 7'h1A: 7-bit target address this block answers to.
- `C_SYNC_STAGES`, default 2: synchronizer depth on SCL and SDA; must be ≥ 2.

- `clk`, in, 1: system clock; single clock domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `scl`, in, 1: bus clock; the target never stretches SCL.
- `sda`, inout, 1: bus data, open-drain; driven `1'b0` or `1'bz` only.
- `start`, out, 1: one-cycle pulse on a detected START or repeated START.
- `stop`, out, 1: one-cycle pulse on a detected STOP.
- `busy`, out, 1: high from an address match until STOP, repeated START, or master NACK.
- `rnw`, out, 1: R/W bit of the last matched address byte; held until the next match.
- `rx_valid`, out, 1: one-cycle pulse when a write data byte is complete.
- `rx_data`, out, 8: last received write byte, MSB first on the wire; held until the next `rx_valid`.
- `tx_data`, in, 8: next read byte; sampled in the cycle `tx_load` is high.
- `tx_load`, out, 1: one-cycle pulse when `tx_data` is captured; user logic presents the following byte afterwards.

## Operation
- Synchronize `scl` and `sda` through `C_SYNC_STAGES` flops. Keep one extra registered copy of each for edge detection.
- START = synchronized SDA falls while SCL is high in both the current and previous sample. STOP = SDA rises under the same SCL condition. A simultaneous SDA change and SCL fall is therefore not a START/STOP.
- Bit sampling happens on the detected SCL rising edge. All SDA drive changes happen on the detected SCL falling edge.
- States, all in `i2c_pkg`:
  - S_IDLE: release SDA; START → S_ADDR.
  - S_ADDR: shift 8 bits.
    - If bits [7:1] == `C_ADDR`: latch `rnw`, set `busy`, go to S_ADDR_ACK.
    - Otherwise go to S_IGNORE.
  - S_ADDR_ACK: drive SDA low from the falling edge after bit 8 to the next falling edge.
    - With rnw=0, go to S_RX_BYTE.
    - With rnw=1, pulse `tx_load`, load the shifter, and go to S_TX_BYTE.
  - S_RX_BYTE: shift 8 bits; at the 8th rising edge, update `rx_data` and pulse `rx_valid`. Go to S_RX_ACK.
  - S_RX_ACK: always ACK (drive low for one SCL low-to-low period), then return to S_RX_BYTE.
  - S_TX_BYTE: on each falling edge, drive SDA low if shifter[7]==0, otherwise release, then shift left. After 8 bits, release SDA and go to S_TX_ACK.
  - S_TX_ACK: sample SDA on the rising edge.
    - Low (ACK): at the next falling edge pulse `tx_load`, reload, and go to S_TX_BYTE.
    - High (NACK): clear `busy` and go to S_IGNORE.
  - S_IGNORE: SDA released; wait for START or STOP.
- START in any state → S_ADDR with bit counter cleared and SDA released. This includes a repeated START mid-byte.
- STOP in any state → S_IDLE, SDA released, `busy` cleared.
- General call (address 0) is not supported: it is treated as a mismatch.

## Timing
- Reset values: `start`, `stop`, `busy`, `rnw`, `rx_valid`, `tx_load` all 0; `rx_data` 8'h00; SDA released; state S_IDLE. Reset mid-transfer releases SDA immediately (asynchronously).
- Pin-to-detect latency is `C_SYNC_STAGES`+1 clk.
- `rx_valid` asserts 1 clk after the 8th rising edge is detected.
- SDA drive changes 1 clk after the falling edge is detected.
- Bus constraints: SCL high and low phases must each be ≥ `C_SYNC_STAGES`+3 clk. With the in-house master on the same clock, this means `C_CLK_DIVISOR` ≥ 12.
- `tx_load` and the shifter load occur in the same clk. `tx_data` must be stable in that cycle.

## Structure
- `i2c_pkg`: state enum `target_state_t`, `C_BYTE_LEN` = 8, ACK/NACK level constants. Shared with the master engine.
- Sub-module `i2c_sync_edge`, instanced for SCL and for SDA: synchronizer chain plus `rise`, `fall`, `level`, `level_prev` outputs.
- Top: FSM, 3-bit bit counter, 8-bit RX/TX shifters, `sda_oe` register (sda = `sda_oe` ? 0 : z).

## Test plan
- Write to 0x1A: START, 0x34, 0xA5, 0x5A, STOP → ACK on all three bytes. `rx_valid` pulses twice with `rx_data` 0xA5 then 0x5A. `start`/`stop` each pulse once.
- Address mismatch: START, 0x36, 0xFF, STOP → SDA never driven, no `rx_valid`, `busy` stays 0.
- Read: START, 0x35, `tx_data` 0xC3 then 0x3C; master ACKs the 1st byte and NACKs the 2nd → bus carries 0xC3 and 0x3C. `tx_load` pulses twice, then the block enters S_IGNORE, and STOP → S_IDLE.
- Repeated START: write 0x34, 0x10, then Sr, 0x35, read one byte → `rnw` goes 0→1, `start` pulses twice, and the read data equals `tx_data`.
- Abort: STOP after 4 bits of a data byte → no `rx_valid`, SDA released, next START/0x34 is ACKed normally.
- Reset: assert `rst` while the target drives the address ACK → SDA is high-Z in the same cycle and all outputs return to reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, byte length and ACK/NACK bus levels.
package i2c_pkg;

    localparam int   C_BYTE_LEN = 8;
    localparam logic C_ACK      = 1'b0;
    localparam logic C_NACK     = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX_BYTE,
        S_RX_ACK,
        S_TX_BYTE,
        S_TX_ACK,
        S_IGNORE
    } target_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer for one bus line plus a registered copy for edge detection.
module i2c_sync_edge #(
    parameter int C_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic level_prev,
    output logic rise,
    output logic fall
);

    logic [C_STAGES-1:0] chain;

    // Reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain      <= '1;
            level_prev <= 1'b1;
        end else begin
            chain      <= {chain[C_STAGES-2:0], pin};
            level_prev <= chain[C_STAGES-1];
        end
    end

    assign level = chain[C_STAGES-1];
    assign rise  = level & ~level_prev;
    assign fall  = ~level & level_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target byte engine: oversampled START/STOP detection, address match,
// write bytes out to user logic and read bytes serialised from tx_data.
//
// state      | meaning
// S_IDLE     | bus free, SDA released
// S_ADDR     | shifting in address + R/W
// S_ADDR_ACK | holding SDA low for the address ACK
// S_RX_BYTE  | shifting in a write data byte
// S_RX_ACK   | holding SDA low for the data ACK
// S_TX_BYTE  | driving a read byte MSB first
// S_TX_ACK   | waiting for the master ACK/NACK
// S_IGNORE   | not addressed, wait for START/STOP
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] C_ADDR        = 7'h1A,
    parameter int         C_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       start,
    output logic       stop,
    output logic       busy,
    output logic       rnw,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic [7:0] tx_data,
    output logic       tx_load
);

    localparam logic [2:0] C_LAST_BIT = 3'(C_BYTE_LEN - 1);

    target_state_t state, state_next;
    logic [2:0] bit_cnt, cnt_next;
    logic [7:0] rx_shift, rx_shift_next, tx_shift, tx_shift_next, rx_data_next;
    logic sda_oe, oe_next, busy_next, rnw_next, rx_valid_next, do_load;
    logic scl_lvl, scl_prev, scl_rise, scl_fall;
    logic sda_lvl, sda_prev, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge #(.C_STAGES(C_SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst(rst), .pin(scl),
        .level(scl_lvl), .level_prev(scl_prev), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.C_STAGES(C_SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst(rst), .pin(sda),
        .level(sda_lvl), .level_prev(sda_prev), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_lvl & scl_prev;
    assign stop_det  = sda_rise & scl_lvl & scl_prev;
    assign sda       = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        state_next    = state;
        cnt_next      = bit_cnt;
        rx_shift_next = rx_shift;
        tx_shift_next = tx_shift;
        rx_data_next  = rx_data;
        oe_next       = sda_oe;
        busy_next     = busy;
        rnw_next      = rnw;
        rx_valid_next = 1'b0;
        do_load       = 1'b0;
        if (start_det) begin
            state_next = S_ADDR;
            cnt_next   = '0;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else if (stop_det) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else begin
            case (state)
                S_ADDR: if (scl_rise) begin
                    rx_shift_next = {rx_shift[6:0], sda_lvl};
                    cnt_next      = bit_cnt + 3'd1;
                    if (bit_cnt == C_LAST_BIT) begin
                        if (rx_shift[6:0] == C_ADDR && rx_shift[6:0] != 7'd0) begin
                            rnw_next   = sda_lvl;
                            busy_next  = 1'b1;
                            state_next = S_ADDR_ACK;
                        end else begin
                            state_next = S_IGNORE;
                        end
                    end
                end
                // First falling edge starts the ACK, the second one ends it.
                S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_next = 1'b1;
                    end else if (state == S_ADDR_ACK && rnw) begin
                        do_load = 1'b1;
                    end else begin
                        oe_next    = 1'b0;
                        state_next = S_RX_BYTE;
                    end
                end
                S_RX_BYTE: if (scl_rise) begin
                    rx_shift_next = {rx_shift[6:0], sda_lvl};
                    cnt_next      = bit_cnt + 3'd1;
                    if (bit_cnt == C_LAST_BIT) begin
                        rx_data_next  = {rx_shift[6:0], sda_lvl};
                        rx_valid_next = 1'b1;
                        state_next    = S_RX_ACK;
                    end
                end
                S_TX_BYTE: if (scl_fall) begin
                    cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == C_LAST_BIT) begin
                        oe_next    = 1'b0;
                        state_next = S_TX_ACK;
                    end else begin
                        oe_next       = ~tx_shift[7];
                        tx_shift_next = {tx_shift[6:0], 1'b0};
                    end
                end
                // NACK needs both samples high; a low glitch on either reads as ACK.
                S_TX_ACK: if (scl_rise && sda_lvl == C_NACK && sda_prev == C_NACK) begin
                    busy_next  = 1'b0;
                    state_next = S_IGNORE;
                end else if (scl_fall) begin
                    do_load = 1'b1;
                end
                default: oe_next = 1'b0;
            endcase
        end
        // Load drives the MSB on the same falling edge that ends the ACK slot.
        if (do_load) begin
            oe_next       = ~tx_data[7];
            tx_shift_next = {tx_data[6:0], 1'b0};
            cnt_next      = '0;
            state_next    = S_TX_BYTE;
        end
        tx_load = do_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            rx_data  <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rnw      <= 1'b0;
            rx_valid <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= cnt_next;
            rx_shift <= rx_shift_next;
            tx_shift <= tx_shift_next;
            rx_data  <= rx_data_next;
            sda_oe   <= oe_next;
            busy     <= busy_next;
            rnw      <= rnw_next;
            rx_valid <= rx_valid_next;
            start    <= start_det;
            stop     <= stop_det;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, transaction-level model and
// an rx_valid scoreboard fed by the master and drained by a monitor.
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h1A;
    localparam int Q = 5;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    logic [7:0] tx_data;
    wire        sda;
    logic       start, stop, busy, rnw, rx_valid, tx_load;
    logic [7:0] rx_data;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;

    i2c_target #(.C_ADDR(ADDR), .C_SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .start(start), .stop(stop), .busy(busy), .rnw(rnw),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_load(tx_load)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int start_cnt = 0, stop_cnt = 0, exp_start = 0, exp_stop = 0, drive_cnt = 0;
    int tx_idx = 0, rd_idx = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_list[64];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pulse counters, target-driven SDA, and the rx scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (start) start_cnt++;
            if (stop) stop_cnt++;
            if (!m_oe && sda === 1'b0) drive_cnt++;
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h, no byte expected", rx_data);
                end else begin
                    check("rx_data", rx_data, rx_q.pop_front());
                end
            end
        end
    end

    // User logic: presents the next read byte after each capture.
    initial forever begin
        @(negedge clk);
        if (!rst && tx_load) begin
            @(posedge clk);
            #1;
            tx_idx++;
            tx_data = tx_list[tx_idx % 64];
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        m_oe = 1'b0; clk_n(Q); scl = 1'b1; clk_n(H);
        m_oe = 1'b1; clk_n(H); scl = 1'b0;
    endtask

    task automatic bus_stop;
        clk_n(Q); m_oe = 1'b1; clk_n(Q); scl = 1'b1; clk_n(H);
        m_oe = 1'b0; clk_n(H);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        clk_n(Q); m_oe = ~b; clk_n(Q); scl = 1'b1; clk_n(H / 2);
        s = (sda === 1'b0) ? 1'b0 : 1'b1;
        clk_n(H / 2); scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(nack, s);
    endtask

    // One transaction: START/Sr, address, n data bytes, optional STOP.
    task automatic xfer(input logic [6:0] a, input logic r, input int n, input logic do_stop,
                        input logic use_fixed, input logic [15:0] fixed);
        logic ack, match;
        logic [7:0] d, exp_b;
        int drv0;
        match = (a == ADDR) && (a != 7'd0);
        drv0 = drive_cnt;
        bus_start;
        exp_start++;
        wr_byte({a, r}, ack);
        check("addr_ack", ack, match ? 0 : 1);
        check("busy_after_addr", busy, match);
        if (match) check("rnw", rnw, r);
        for (int i = 0; i < n; i++) begin
            if (!r) begin
                d = use_fixed ? ((i == 0) ? fixed[15:8] : fixed[7:0]) : 8'($urandom);
                if (match) rx_q.push_back(d);
                wr_byte(d, ack);
                check("data_ack", ack, match ? 0 : 1);
            end else begin
                rd_byte(i == n - 1, d);
                exp_b = match ? tx_list[rd_idx] : 8'hFF;
                if (match) rd_idx++;
                check("read_data", d, exp_b);
            end
        end
        clk_n(4);
        if (match && r) begin
            check("tx_load_count", tx_idx, rd_idx);
            check("busy_after_nack", busy, 0);
        end
        if (!match) check("no_drive", drive_cnt - drv0, 0);
        if (do_stop) begin
            bus_stop;
            exp_stop++;
            check("busy_after_stop", busy, 0);
            check("sda_released", (sda === 1'b0) ? 0 : 1, 1);
        end
        check("rx_pending", rx_q.size(), 0);
        check("start_cnt", start_cnt, exp_start);
        check("stop_cnt", stop_cnt, exp_stop);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rnw"}, rnw, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_pulses"}, {start, stop, rx_valid, tx_load}, 0);
        check({tag, "_sda"}, (sda === 1'b0) ? 0 : 1, 1);
    endtask

    initial begin
        logic ack, s, last_stop;
        logic [6:0] a;
        for (int i = 0; i < 64; i++) tx_list[i] = 8'($urandom);
        tx_list[0] = 8'hC3;
        tx_list[1] = 8'h3C;
        tx_data = tx_list[0];

        clk_n(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        clk_n(10);
        check_reset_outputs("idle");

        xfer(ADDR, 1'b0, 2, 1'b1, 1'b1, 16'hA55A);
        xfer(7'h1B, 1'b0, 1, 1'b1, 1'b1, 16'hFF00);
        xfer(ADDR, 1'b1, 2, 1'b1, 1'b0, 16'h0000);
        xfer(ADDR, 1'b0, 1, 1'b0, 1'b1, 16'h1000);
        xfer(ADDR, 1'b1, 1, 1'b1, 1'b0, 16'h0000);

        // Abort: STOP four bits into a write data byte.
        bus_start;
        exp_start++;
        wr_byte(8'h34, ack);
        check("abort_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
        bus_stop;
        exp_stop++;
        clk_n(4);
        check("abort_busy", busy, 0);
        check("abort_sda", (sda === 1'b0) ? 0 : 1, 1);
        check("abort_stop_cnt", stop_cnt, exp_stop);
        xfer(ADDR, 1'b0, 1, 1'b1, 1'b1, 16'h6700);

        // Reset while the target holds the address ACK.
        bus_start;
        exp_start++;
        for (int i = 7; i >= 0; i--) bus_bit(i == 0 ? 1'b0 : ((8'h34 >> i) & 1) != 0, s);
        m_oe = 1'b0;
        clk_n(4);
        check("ack_driven", (sda === 1'b0) ? 1 : 0, 1);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        clk_n(3);
        rst = 1'b0;
        clk_n(10);
        bus_stop;
        exp_stop++;
        check("post_rst_start_cnt", start_cnt, exp_start);
        check("post_rst_stop_cnt", stop_cnt, exp_stop);

        last_stop = 1'b1;
        repeat (16) begin
            a = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom_range(0, 127));
            if (a == ADDR && $urandom_range(0, 3) == 0) a = 7'd0;
            last_stop = ($urandom_range(0, 3) != 0);
            xfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), last_stop, 1'b0, 16'h0000);
        end
        if (!last_stop) begin
            bus_stop;
            exp_stop++;
            check("final_stop_cnt", stop_cnt, exp_stop);
        end

        clk_n(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
